// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, line levels and framing constants shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   FRAME_BITS = 10;

    function automatic logic line_level(input uart_state_t s, input logic d);
        return (s == START) ? START_BIT : (s == DATA) ? d : (s == STOP) ? STOP_BIT : IDLE_LEVEL;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer; tick is high during the last clk of every CLKS_PER_BIT-cycle period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !enable)
            count <= '0;
        else
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser with a valid/ready byte handshake and registered line outputs.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state, state_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic                 tick;
    logic                 accept;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk(clk),
        .reset(reset),
        .enable(state != IDLE),
        .tick(tick)
    );

    assign accept = tx_valid && tx_ready;

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_idx_nx = bit_idx;
        case (state)
            IDLE: if (accept) begin
                state_nx = START;
                shift_nx = tx_data;
            end
            START: if (tick) state_nx = DATA;
            DATA: if (tick) begin
                shift_nx   = shift >> 1;
                bit_idx_nx = (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
                state_nx   = (bit_idx == LAST_BIT) ? STOP : DATA;
            end
            STOP: if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            tx       <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            shift    <= shift_nx;
            bit_idx  <= bit_idx_nx;
            tx       <= line_level(state_nx, shift_nx[0]);
            tx_ready <= (state_nx == IDLE);
            busy     <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (CLKS_PER_BIT 4, 2, 16) checked every cycle against a frame-position model and a line decoder.
module tb_uart_tx;

    localparam int N = 3;

    logic           clk;
    logic           reset;
    logic [N-1:0]   valid;
    logic [7:0]     data [N];
    logic [N-1:0]   ready;
    logic [N-1:0]   tx;
    logic [N-1:0]   busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         pos [N];
    logic [7:0] mdata [N];
    int         acc_cnt [N];
    int         acc_cyc [N];
    logic [7:0] exp_mem [N][64];
    int         wr [N];
    int         rd [N];

    int         dpos [N];
    logic [9:0] dbits [N];
    int         dstart [N];
    int         start_gap [N];
    int         run0 [N];
    int         last_low [N];
    int         dec_cnt [N];
    logic [7:0] dec_last [N];
    logic [7:0] dec_prev [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx #(.CLKS_PER_BIT(g == 0 ? 4 : g == 1 ? 2 : 16)) dut (
            .clk(clk),
            .reset(reset),
            .tx_data(data[g]),
            .tx_valid(valid[g]),
            .tx_ready(ready[g]),
            .tx(tx[g]),
            .busy(busy[g])
        );
    end

    function automatic int cpb(input int k);
        return k == 0 ? 4 : k == 1 ? 2 : 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: a frame occupies 10*C cycles after the accept edge; bit b of the frame is position/C.
    initial begin
        logic         r;
        logic [N-1:0] v;
        logic [7:0]   d [N];
        for (int k = 0; k < N; k++) begin
            pos[k] = -1; acc_cnt[k] = 0; acc_cyc[k] = 0; wr[k] = 0; rd[k] = 0; mdata[k] = '0;
            dpos[k] = -1; dbits[k] = '0; dstart[k] = 0; start_gap[k] = 0; run0[k] = 0;
            last_low[k] = 0; dec_cnt[k] = 0; dec_last[k] = '0; dec_prev[k] = '0;
        end
        forever begin
            @(posedge clk);
            r = reset;
            v = valid;
            for (int k = 0; k < N; k++) d[k] = data[k];
            cyc++;
            #1;
            for (int k = 0; k < N; k++) begin
                int   c;
                int   b;
                logic etx;
                c = cpb(k);
                if (r) begin
                    pos[k] = -1;
                    rd[k]  = wr[k];
                end else if (pos[k] < 0) begin
                    if (v[k]) begin
                        pos[k]   = 0;
                        mdata[k] = d[k];
                        acc_cnt[k]++;
                        acc_cyc[k] = cyc;
                        exp_mem[k][wr[k] % 64] = d[k];
                        wr[k]++;
                    end
                end else begin
                    pos[k]++;
                    if (pos[k] == 10 * c) pos[k] = -1;
                end
                b   = pos[k] / c;
                etx = (pos[k] < 0) ? 1'b1 : (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mdata[k][b - 1];
                chk($sformatf("tx%0d cyc%0d", k, cyc), 32'(tx[k]), 32'(etx));
                chk($sformatf("ready%0d cyc%0d", k, cyc), 32'(ready[k]), 32'(pos[k] < 0));
                chk($sformatf("busy%0d cyc%0d", k, cyc), 32'(busy[k]), 32'(pos[k] >= 0));

                // Far-end receiver: centre-sampling decode of the DUT line.
                if (r) begin
                    dpos[k] = -1;
                    run0[k] = 0;
                end else begin
                    if (tx[k] === 1'b0) run0[k]++;
                    else begin
                        if (run0[k] > 0) last_low[k] = run0[k];
                        run0[k] = 0;
                    end
                    if (dpos[k] < 0 && tx[k] === 1'b0) begin
                        dpos[k]      = 0;
                        start_gap[k] = cyc - dstart[k];
                        dstart[k]    = cyc;
                    end
                    if (dpos[k] >= 0) begin
                        if (dpos[k] % c == c / 2) dbits[k][dpos[k] / c] = tx[k];
                        if (dpos[k] == 9 * c + c / 2) begin
                            dpos[k] = -1;
                            dec_cnt[k]++;
                            dec_prev[k] = dec_last[k];
                            dec_last[k] = dbits[k][8:1];
                            chk($sformatf("framing%0d", k), 32'({dbits[k][9], dbits[k][0]}), 32'(2'b10));
                            if (rd[k] == wr[k]) chk($sformatf("unexpected_frame%0d", k), 32'(1), 32'(0));
                            else begin
                                chk($sformatf("byte%0d", k), 32'(dbits[k][8:1]), 32'(exp_mem[k][rd[k] % 64]));
                                rd[k]++;
                            end
                        end else dpos[k]++;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_acc(input int k, input int n0);
        int t = 0;
        while (acc_cnt[k] <= n0 && t < 2000) begin
            step(1);
            t++;
        end
        if (acc_cnt[k] <= n0) chk($sformatf("accept_timeout%0d", k), 32'(0), 32'(1));
    endtask

    task automatic send(input int k, input logic [7:0] b);
        int n0 = acc_cnt[k];
        valid[k] = 1'b1;
        data[k]  = b;
        wait_acc(k, n0);
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while (!(pos[k] < 0 && dpos[k] < 0) && t < 2000) begin
            step(1);
            t++;
        end
        if (t >= 2000) chk($sformatf("idle_timeout%0d", k), 32'(0), 32'(1));
        step(2);
    endtask

    initial begin
        int a1;
        int a2;
        int c;
        int n;
        reset = 1'b1;
        valid = '0;
        for (int k = 0; k < N; k++) data[k] = '0;
        step(1);
        chk("reset_tx", 32'(tx), 32'(3'b111));
        chk("reset_ready", 32'(ready), 32'(3'b111));
        chk("reset_busy", 32'(busy), 32'(3'b000));
        step(2);
        reset = 1'b0;
        step(2);

        send(0, 8'h55);
        c = 0;
        while (ready[0] !== 1'b1 && c < 200) begin
            step(1);
            c++;
        end
        chk("ready_return", 32'(c + 1), 32'(41));
        wait_idle(0);
        chk("bits_0x55", 32'(dbits[0]), 32'(10'b1010101010));

        n = acc_cnt[0];
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        wait_acc(0, n);
        a1 = acc_cyc[0];
        data[0] = 8'h3C;
        wait_acc(0, n + 1);
        a2 = acc_cyc[0];
        valid[0] = 1'b0;
        wait_idle(0);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'(41));
        chk("b2b_start_gap", 32'(start_gap[0]), 32'(41));
        chk("b2b_first", 32'(dec_prev[0]), 32'(8'hA5));
        chk("b2b_second", 32'(dec_last[0]), 32'(8'h3C));

        n = dec_cnt[0];
        send(0, 8'h00);
        c = 0;
        while (pos[0] < 20 && c < 100) begin
            step(1);
            c++;
        end
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        step(1);
        valid[0] = 1'b0;
        wait_idle(0);
        step(8);
        chk("busy_frames", 32'(dec_cnt[0] - n), 32'(1));
        chk("busy_byte", 32'(dec_last[0]), 32'(8'h00));
        chk("busy_line_high", 32'(tx[0]), 32'(1));

        send(0, 8'h81);
        data[0] = 8'h7E;
        wait_idle(0);
        chk("data_change", 32'(dec_last[0]), 32'(8'h81));

        n = dec_cnt[0];
        send(0, 8'h5A);
        c = 0;
        while (pos[0] != 17 && c < 100) begin
            step(1);
            c++;
        end
        reset = 1'b1;
        step(1);
        chk("midreset_tx", 32'(tx[0]), 32'(1));
        chk("midreset_ready", 32'(ready[0]), 32'(1));
        chk("midreset_busy", 32'(busy[0]), 32'(0));
        reset = 1'b0;
        step(1);
        send(0, 8'hC3);
        wait_idle(0);
        chk("after_reset_frames", 32'(dec_cnt[0] - n), 32'(1));
        chk("after_reset_byte", 32'(dec_last[0]), 32'(8'hC3));

        for (int k = 1; k < N; k++) begin
            send(k, 8'h00);
            wait_idle(k);
            chk($sformatf("period%0d_00", k), 32'(dec_last[k]), 32'(8'h00));
            chk($sformatf("low_run%0d_00", k), 32'(last_low[k]), 32'(9 * cpb(k)));
            send(k, 8'hFF);
            wait_idle(k);
            chk($sformatf("period%0d_ff", k), 32'(dec_last[k]), 32'(8'hFF));
            chk($sformatf("low_run%0d_ff", k), 32'(last_low[k]), 32'(cpb(k)));
        end

        for (int i = 0; i < 24; i++) begin
            send($urandom_range(0, N - 1), 8'($urandom_range(0, 255)));
            step($urandom_range(0, 25));
        end
        for (int k = 0; k < N; k++) begin
            wait_idle(k);
            chk($sformatf("queue_empty%0d", k), 32'(wr[k] - rd[k]), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one parallel byte per handshake into an asynchronous 8N1 frame (start bit, 8 data bits LSB first, stop bit) on a single output line. It pairs with the UART receiver on the far end of the link and shares its bit-period definition. Upstream logic hands bytes in over a valid/ready handshake, and the block owns bit timing internally.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range ≥ 2.
- DATA_BITS, default 8: data bits per frame; fixed at 8 for this release.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- tx_data  input  8  byte to send; sampled only on acceptance.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept; byte accepted on any rising edge with tx_valid && tx_ready.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress (start through stop bit).

## Operation
- Registered outputs. Reset values: tx=1, tx_ready=1, busy=0. Internal reset values: state=IDLE, bit counter=0, tick counter=0, shift register=0.
- States and transitions:
  - IDLE → START on accept. The accept edge latches tx_data into the shift register.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- tx drive per state: IDLE=1, START=0, DATA=shift[0], STOP=1.
- Shift register shifts right by one at the end of each data-bit period, so data is sent LSB first.
- Tick counter has width $clog2(CLKS_PER_BIT):
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0. Each wrap ends a bit period.
  - Held at 0 in IDLE.
- Bit index is 3 bits, counts 0..7 in DATA, and is cleared on leaving DATA.
- tx_ready=1 only in IDLE. busy is the inverse of tx_ready.
- tx_valid while tx_ready=0: ignored. No queuing and no error flag. Upstream must hold tx_valid.
- tx_data changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: the frame is abandoned. On the next edge, tx=1 and state=IDLE. No partial stop bit is guaranteed.
- Reset and tx_valid on the same edge: reset wins and no byte is accepted.

## Timing
- Accept on edge E:
  - tx falls and busy rises at E+1.
  - Start bit spans edges E+1..E+CLKS_PER_BIT.
  - Data bit n spans E+1+(n+1)·CLKS_PER_BIT for CLKS_PER_BIT cycles.
  - Stop bit begins at E+1+9·CLKS_PER_BIT.
- tx_ready reasserts at edge E+1+10·CLKS_PER_BIT, the first edge after the stop period. A new accept is possible on that same edge's following cycle.
- Back-to-back throughput: one frame every 10·CLKS_PER_BIT+1 cycles. The single extra cycle is idle-high and does not violate the receiver's start-bit detection.
- Every bit lasts exactly CLKS_PER_BIT cycles, with no jitter and no cumulative drift.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1, FRAME_BITS=10.
- The receiver imports the same package.
- One natural sub-module, uart_baud_tick:
  - parameterised by CLKS_PER_BIT;
  - inputs: clk, reset, enable;
  - output: a one-cycle tick at the end of each bit period;
  - held cleared when enable=0.
- The same sub-module is reusable by the receiver.

## Test plan
- **Single byte.** CLKS_PER_BIT=4; send 0x55 with one accept. Required: tx samples at bit centres give 0,1,0,1,0,1,0,1,0,1; tx_ready returns exactly 41 cycles after accept.
- **Back-to-back.** Send 0xA5 with tx_valid held, then 0x3C. Required: decoded bytes are 0xA5 then 0x3C; exactly one idle-high cycle between the stop bit and the next start bit.
- **Valid while busy.** Pulse tx_valid with 0xFF mid-frame of 0x00. Required: only 0x00 is transmitted; tx stays high after its stop bit.
- **Data change after accept.** Accept 0x81, then change tx_data to 0x7E on the next cycle. Required: line carries 0x81.
- **Reset mid-frame.** Assert reset during data bit 3. Required: tx=1, tx_ready=1, busy=0 on the next edge. A following 0xC3 then transmits correctly.
- **Bit-period check.** CLKS_PER_BIT=2 and CLKS_PER_BIT=16 with bytes 0x00 and 0xFF. Required: every bit width equals CLKS_PER_BIT cycles exactly; the receiver model decodes without framing error.
